// File: rtl/tick_rate_generator.sv
// Two-stage clock-enable tick generator: fast ticks every PRESCALE cycles, slow ticks every SLOW_DIV fast ticks.
// Optional 50 % duty square outputs are built only when TICK_SQUARE_OUT_EN is defined.
module tick_rate_generator #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int FAST_HZ     = 100,
  parameter int SLOW_DIV    = 100
) (
  input  logic CLK_50MHz,
  input  logic rst,
  input  logic en,
  input  logic sync_clr,
  output logic tick_fast,
  output logic tick_slow,
  output logic sq_fast,
  output logic sq_slow
);

  localparam int PRESCALE = CLK_FREQ_HZ / FAST_HZ;
  localparam int W0 = $clog2(PRESCALE);
  localparam int W1 = $clog2(SLOW_DIV);

  localparam logic [W0-1:0] C0_TERM = W0'(PRESCALE - 1);
  localparam logic [W1-1:0] C1_TERM = W1'(SLOW_DIV - 1);

  if (CLK_FREQ_HZ % FAST_HZ != 0) begin : g_bad_ratio
    $fatal(1, "tick_rate_generator: CLK_FREQ_HZ must be a multiple of FAST_HZ");
  end
  if (PRESCALE < 2 || PRESCALE % 2 != 0) begin : g_bad_prescale
    $fatal(1, "tick_rate_generator: PRESCALE must be even and >= 2");
  end
  if (SLOW_DIV < 2 || SLOW_DIV % 2 != 0) begin : g_bad_slow_div
    $fatal(1, "tick_rate_generator: SLOW_DIV must be even and >= 2");
  end

  logic [W0-1:0] cnt0;
  logic [W1-1:0] cnt1;
  logic          wrap0;
  logic          wrap1;

  assign wrap0 = (cnt0 == C0_TERM);
  assign wrap1 = (cnt1 == C1_TERM);

  // Priority per edge: sync_clr, then en; a hold freezes counters and drops ticks.
  always_ff @(posedge CLK_50MHz or posedge rst) begin
    if (rst) begin
      cnt0      <= '0;
      cnt1      <= '0;
      tick_fast <= 1'b0;
      tick_slow <= 1'b0;
    end else if (sync_clr) begin
      cnt0      <= '0;
      cnt1      <= '0;
      tick_fast <= 1'b0;
      tick_slow <= 1'b0;
    end else if (en) begin
      cnt0      <= wrap0 ? '0 : cnt0 + W0'(1);
      tick_fast <= wrap0;
      if (wrap0) begin
        cnt1 <= wrap1 ? '0 : cnt1 + W1'(1);
      end
      tick_slow <= wrap0 && wrap1;
    end else begin
      tick_fast <= 1'b0;
      tick_slow <= 1'b0;
    end
  end

`ifdef TICK_SQUARE_OUT_EN
  localparam logic [W0-1:0] C0_HALF = W0'(PRESCALE / 2 - 1);
  localparam logic [W1-1:0] C1_HALF = W1'(SLOW_DIV / 2 - 1);

  // High for the second half of each counter period; sq_slow only moves on fast wraps.
  always_ff @(posedge CLK_50MHz or posedge rst) begin
    if (rst) begin
      sq_fast <= 1'b0;
      sq_slow <= 1'b0;
    end else if (sync_clr) begin
      sq_fast <= 1'b0;
      sq_slow <= 1'b0;
    end else if (en) begin
      if (wrap0) begin
        sq_fast <= 1'b0;
      end else if (cnt0 == C0_HALF) begin
        sq_fast <= 1'b1;
      end
      if (wrap0) begin
        if (wrap1) begin
          sq_slow <= 1'b0;
        end else if (cnt1 == C1_HALF) begin
          sq_slow <= 1'b1;
        end
      end
    end
  end
`else
  assign sq_fast = 1'b0;
  assign sq_slow = 1'b0;
`endif

endmodule

// File: tb/tb_tick_rate_generator.sv
// Bench for tick_rate_generator: directed latency scenarios plus randomized en/sync_clr/rst traffic,
// scored against an enabled-edge-count reference model.
module tb_tick_rate_generator;

  localparam int CLK_HZ = 1000;
  localparam int FAST   = 100;
  localparam int SDIV   = 4;
  localparam int P      = CLK_HZ / FAST;
  localparam int PS     = P * SDIV;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic sync_clr;
  logic tick_fast;
  logic tick_slow;
  logic sq_fast;
  logic sq_slow;

  int tests_run    = 0;
  int tests_failed = 0;
  int en_count     = 0;
  logic [3:0] exp_q[$];

  tick_rate_generator #(
    .CLK_FREQ_HZ(CLK_HZ),
    .FAST_HZ    (FAST),
    .SLOW_DIV   (SDIV)
  ) dut (
    .CLK_50MHz(clk),
    .rst      (rst),
    .en       (en),
    .sync_clr (sync_clr),
    .tick_fast(tick_fast),
    .tick_slow(tick_slow),
    .sq_fast  (sq_fast),
    .sq_slow  (sq_slow)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] outs();
    return {tick_fast, tick_slow, sq_fast, sq_slow};
  endfunction

  // Reference: everything follows from the number of enabled edges since the last clear.
  task automatic model_edge(input bit e, input bit c);
    logic tf, ts, sf, ss;
    tf = 1'b0;
    ts = 1'b0;
    if (c) begin
      en_count = 0;
    end else if (e) begin
      en_count++;
      tf = (en_count % P == 0);
      ts = (en_count % PS == 0);
    end
`ifdef TICK_SQUARE_OUT_EN
    sf = ((en_count % P) >= P / 2);
    ss = ((en_count % PS) >= PS / 2);
`else
    sf = 1'b0;
    ss = 1'b0;
`endif
    exp_q.push_back({tf, ts, sf, ss});
  endtask

  // driver: apply inputs, clock one edge, score outputs 1 ns later
  task automatic step(input bit e, input bit c, output bit tf, output bit ts);
    logic [3:0] exp;
    en       = e;
    sync_clr = c;
    model_edge(e, c);
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("outputs", 32'(outs()), 32'(exp));
    tf = tick_fast;
    ts = tick_slow;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    en       = 1'b0;
    sync_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs()), 32'd0);
    rst      = 1'b0;
    en_count = 0;
  endtask

  // short reset pulse placed mid-cycle, entered 1 ns after an edge
  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check("async_rst_in", 32'(outs()), 32'd0);
    #2 rst = 1'b0;
    en_count = 0;
    check("async_rst_out", 32'(outs()), 32'd0);
  endtask

  // enabled edges until the chosen tick appears, bounded
  task automatic edges_until(input bit slow, output int n);
    bit tf, ts;
    n = 0;
    do begin
      step(1'b1, 1'b0, tf, ts);
      n++;
    end while (!(slow ? ts : tf) && n < 200);
  endtask

  initial begin
    bit tf, ts;
    int n, nf, ns;

    // plan 1: free run from release
    do_reset();
    nf = 0;
    ns = 0;
    for (int i = 1; i <= 2 * PS; i++) begin
      step(1'b1, 1'b0, tf, ts);
      if (tf) nf++;
      if (ts) ns++;
      if (i == P)  check("first_fast", 32'(tf), 32'd1);
      if (i == PS) check("first_slow", 32'(ts), 32'd1);
    end
    check("fast_count_80", 32'(nf), 32'(2 * PS / P));
    check("slow_count_80", 32'(ns), 32'd2);

    // plan 2: 7-edge hold after cycle 5
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, tf, ts);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, tf, ts);
    edges_until(1'b0, n);
    check("hold_latency", 32'(5 + 7 + n), 32'd17);

    // plan 3: sync_clr at cycle 25
    do_reset();
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, tf, ts);
    step(1'b1, 1'b1, tf, ts);
    edges_until(1'b0, n);
    check("clr_fast_latency", 32'(n), 32'(P));
    edges_until(1'b1, n);
    check("clr_slow_latency", 32'(P + n), 32'(PS));

    // plan 4: async reset pulse at cycle 33
    do_reset();
    for (int i = 0; i < 33; i++) step(1'b1, 1'b0, tf, ts);
    async_reset();
    edges_until(1'b0, n);
    check("rst_pulse_latency", 32'(n), 32'(P));

    // plan 5: sync_clr with en=0 on the terminal edge
    do_reset();
    for (int i = 0; i < P - 1; i++) step(1'b1, 1'b0, tf, ts);
    step(1'b0, 1'b1, tf, ts);
    edges_until(1'b0, n);
    check("clr_beats_hold", 32'(n), 32'(P));

    // hold exactly on the terminal edge: tick deferred to first edge after en returns
    do_reset();
    for (int i = 0; i < P - 1; i++) step(1'b1, 1'b0, tf, ts);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, tf, ts);
    step(1'b1, 1'b0, tf, ts);
    check("terminal_hold_tick", 32'(tf), 32'd1);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0), tf, ts);
      if ($urandom_range(0, 199) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tick_rate_generator.md
Name: tick_rate_generator

Overview:
- Parametrised successor to the fixed 50 MHz → 100 Hz / 1 Hz divider used by the two-mode timer.
- Generates single-cycle clock-enable ticks at two cascaded rates from one system clock. Downstream logic stays on CLK_50MHz and no derived clocks are created.
- Adds run/hold control, synchronous phase realignment, and optional 50 % duty square outputs for display and LED use.
- Sits between the board clock and the timer/stopwatch counters.

Parameters:
- CLK_FREQ_HZ, 50000000, input clock frequency in Hz.
- FAST_HZ, 100, fast tick rate. PRESCALE = CLK_FREQ_HZ / FAST_HZ.
- SLOW_DIV, 100, fast ticks per slow tick. Slow rate = FAST_HZ / SLOW_DIV.
- Legality, checked at elaboration (otherwise fatal error):
  - CLK_FREQ_HZ % FAST_HZ == 0.
  - PRESCALE ≥ 2 and even.
  - SLOW_DIV ≥ 2 and even.
- Counter widths are derived with $clog2 and are not user parameters.

Ports:
- CLK_50MHz  in  1  system clock, rising edge. Name retained even when CLK_FREQ_HZ differs.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run (1) / hold (0).
- sync_clr  in  1  synchronous phase realign. Clears both counters.
- tick_fast  out  1  one-cycle pulse at FAST_HZ.
- tick_slow  out  1  one-cycle pulse at slow rate. Always coincident with a tick_fast.
- sq_fast  out  1  square wave at FAST_HZ (optional feature).
- sq_slow  out  1  square wave at slow rate (optional feature).

Behaviour:
- Reset: cnt0, cnt1, tick_fast, tick_slow, sq_fast and sq_slow go to 0 immediately and asynchronously, independent of the clock. All outputs are registered.
- Cycle numbering: "cycle n" means the interval after the n-th rising edge sampled with rst=0, en=1, sync_clr=0.
- Priority per edge: sync_clr > en > hold.
- sync_clr=1: cnt0, cnt1, tick_fast, tick_slow, sq_fast, sq_slow ← 0 on that edge. The next tick_fast occurs PRESCALE enabled edges later.
- en=1, sync_clr=0, stage 0:
  - If cnt0 == PRESCALE-1: cnt0 ← 0, tick_fast ← 1.
  - Else: cnt0 ← cnt0+1, tick_fast ← 0.
- en=1, sync_clr=0, stage 1 (advances only on an edge where stage 0 wraps):
  - If cnt1 == SLOW_DIV-1: cnt1 ← 0, tick_slow ← 1.
  - Else: cnt1 ← cnt1+1.
  - tick_slow ← 0 on every other edge.
- en=0, sync_clr=0: cnt0, cnt1, sq_fast and sq_slow hold. tick_fast and tick_slow ← 0, so no pulse stretches across a hold.
- Latency: the first tick_fast is high in cycle PRESCALE. tick_slow is high in cycle PRESCALE·SLOW_DIV.
- Pulse width: ticks are exactly one cycle wide. Spacing is PRESCALE (fast) or PRESCALE·SLOW_DIV (slow) enabled cycles.
- Wrap-around: counters never exceed their terminal value. No overflow state exists.
- sync_clr and en asserted together: sync_clr wins.
- en deasserted on a terminal edge: no tick, and the counter holds at its terminal value. The tick fires on the first edge after en returns.

Optional Feature:
- Macro: TICK_SQUARE_OUT_EN.
- Defined:
  - sq_fast ← 1 on the enabled edge where cnt0 goes PRESCALE/2-1 → PRESCALE/2.
  - sq_fast ← 0 on the stage-0 wrap edge.
  - sq_slow does the same using cnt1 over SLOW_DIV/2, updated only on stage-0 wrap edges.
  - Result: 50 % duty, periods PRESCALE and PRESCALE·SLOW_DIV enabled cycles. Both are cleared by rst and sync_clr.
- Undefined: sq_fast and sq_slow are constant 0, and no square-wave logic is synthesised. The ports remain for interface stability.

Test Plan (CLK_FREQ_HZ=1000, FAST_HZ=100, SLOW_DIV=4 → PRESCALE=10, 10 ns clock):
- Reset release, en=1 held → tick_fast high exactly in cycles 10, 20, 30, 40. tick_slow high only in cycle 40, then 80. No other pulses.
- en=0 for 7 edges starting after cycle 5 → first tick_fast delayed to 17 edges after reset release. tick_fast=0 throughout the hold.
- sync_clr one edge at cycle 25 → next tick_fast 10 enabled edges after the clear. tick_slow appears on the 4th subsequent tick_fast (40 edges after the clear).
- rst pulsed 3 ns mid-cycle at cycle 33 → all outputs 0 before the next edge. First tick_fast 10 edges after release.
- sync_clr and en=0 asserted together on the cycle-9 edge → counters cleared, not held. Next tick_fast 10 enabled edges after release.
- Build with TICK_SQUARE_OUT_EN:
  - sq_fast: 5 high / 5 low, rising 5 edges after release.
  - sq_slow: 20 high / 20 low.
  - Without the macro, both stay 0 for 1000 cycles.
